cv32e40p_data_mem_arbiter: RTL
==============================

CV32E40P_DATA_MEM_ARBITER -- requirements
Module: cv32e40p_data_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted transactions still awaiting rvalid (legal range 1..4).
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port m{0,1}_req_i  input  1  requester N transaction request.
REQ-005 SHALL have port m{0,1}_we_i  input  1  requester N write enable.
REQ-006 SHALL have port m{0,1}_be_i  input  4  requester N byte enables.
REQ-007 SHALL have port m{0,1}_addr_i  input  32  requester N address.
REQ-008 SHALL have port m{0,1}_wdata_i  input  32  requester N write data.
REQ-009 SHALL have port m{0,1}_gnt_o  output  1  requester N address-phase grant.
REQ-010 SHALL have port m{0,1}_rvalid_o  output  1  requester N response valid.
REQ-011 SHALL have port m{0,1}_rdata_o  output  32  requester N read data.
REQ-012 SHALL have ports data_req_o, data_we_o, data_be_o[3:0], data_addr_o[31:0], data_wdata_o[31:0]  output  shared data memory request channel.
REQ-013 SHALL have ports data_gnt_i, data_rvalid_i, data_rdata_i[31:0]  input  shared data memory grant/response.
REQ-014 SHALL have port err_unexp_rvalid_o  output  1  one-cycle pulse on rvalid with no outstanding transaction.

Function
REQ-015 SHALL run FSM with states ARB and HOLD; reset state ARB.
REQ-016 In ARB, SHALL select among asserted mN_req_i by round-robin; priority pointer rr_q (reset 0 = m0 preferred) toggles to the other requester on each data_gnt_i.
REQ-017 SHALL drive data_req_o=1 and mux the winner's we/be/addr/wdata onto data_* combinationally in the same cycle mN_req_i is seen (zero-cycle request latency).
REQ-018 If data_req_o=1 and data_gnt_i=0, SHALL transition ARB->HOLD and lock the selected requester; in HOLD the selection SHALL NOT change regardless of other requests.
REQ-019 In HOLD, SHALL go to ARB on data_gnt_i=1; if locked requester drops req (protocol violation) SHALL deassert data_req_o and return to ARB.
REQ-020 SHALL pass data_gnt_i combinationally to the selected requester's gnt; the non-selected gnt SHALL be 0.
REQ-021 SHALL suppress data_req_o (and all mN_gnt_o) while outstanding count == MAX_OUTSTANDING.
REQ-022 On data_req_o && data_gnt_i SHALL push winner ID into an in-order ID FIFO and increment count.
REQ-023 On data_rvalid_i with count>0 SHALL pop FIFO head, assert rvalid only to head requester, same cycle (zero latency), decrement count.
REQ-024 SHALL broadcast data_rdata_i to both mN_rdata_o; consumers qualify by rvalid.
REQ-025 Simultaneous grant and rvalid SHALL push and pop in the same cycle, count unchanged, FIFO order preserved.
REQ-026 data_rvalid_i with count==0 SHALL pulse err_unexp_rvalid_o for one cycle, assert no mN_rvalid_o, leave state unchanged.
REQ-027 Count width SHALL be $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-028 rst_ni low SHALL immediately force FSM=ARB, rr_q=0, count=0, FIFO pointers=0; err_unexp_rvalid_o=0.
REQ-029 During reset all gnt/rvalid outputs and data_req_o SHALL be 0; in-flight transactions are discarded, and rvalid after reset release flags REQ-026.

Structure
REQ-030 SHALL place requester-ID type, FSM state enum and MAX_OUTSTANDING default in cv32e40p_data_mem_arb_pkg.
REQ-031 SHALL implement the ID FIFO as sub-module cv32e40p_data_mem_arb_id_fifo (push/pop/full/empty/head).

Verification
REQ-032 Both req held, memory gnt every cycle, rvalid 1 cycle later -> grants alternate m0,m1,m0,m1; each rvalid routed to matching requester.
REQ-033 m1 req at addr 0x100, gnt withheld 3 cycles while m0 raises req -> data_addr_o stays 0x100, m0_gnt_o=0 until m1 granted.
REQ-034 MAX_OUTSTANDING=2, two grants, no rvalid -> third request sees data_req_o=0 until first rvalid.
REQ-035 Grant and rvalid same cycle at count=1 -> count stays 1, response to older requester.
REQ-036 rvalid with no outstanding -> err_unexp_rvalid_o high exactly one cycle, m0/m1_rvalid_o=0.
REQ-037 rst_ni low with 2 outstanding -> count=0, outputs 0; later stray rvalid flags error.

Source files
------------

// File: rtl/cv32e40p_data_mem_arb_pkg.sv
// rtl/cv32e40p_data_mem_arb_pkg.sv - shared types and defaults for the data memory arbiter
package cv32e40p_data_mem_arb_pkg;

    localparam int MAX_OUTSTANDING_DEFAULT = 2;

    typedef logic req_id_t;
    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cv32e40p_data_mem_arb_id_fifo.sv
// rtl/cv32e40p_data_mem_arb_id_fifo.sv - in-order requester ID FIFO for outstanding transactions
module cv32e40p_data_mem_arb_id_fifo
    import cv32e40p_data_mem_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  req_id_t          id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output req_id_t          head_o,
    output logic [CNT_W-1:0] count_o
);

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_M0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_data_mem_arbiter.sv
// rtl/cv32e40p_data_mem_arbiter.sv - two-requester round-robin arbiter onto one OBI-style data port
module cv32e40p_data_mem_arbiter
    import cv32e40p_data_mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,

    output logic        err_unexp_rvalid_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       state_q, state_d;
    req_id_t          rr_q, rr_d;
    req_id_t          lock_q, lock_d;
    req_id_t          winner;
    logic             sel_req;
    logic             fifo_full;
    logic             fifo_empty;
    req_id_t          head_id;
    logic [CNT_W-1:0] out_cnt;
    logic             push;
    logic             pop;

    // In HOLD the locked requester owns the port; a dropped request frees it.
    always_comb begin
        winner  = rr_q;
        sel_req = 1'b0;
        if (state_q == HOLD) begin
            winner  = lock_q;
            sel_req = (lock_q == REQ_M1) ? m1_req_i : m0_req_i;
        end else begin
            sel_req = m0_req_i || m1_req_i;
            if (m0_req_i && m1_req_i) begin
                winner = rr_q;
            end else if (m1_req_i) begin
                winner = REQ_M1;
            end else begin
                winner = REQ_M0;
            end
        end
    end

    assign data_req_o   = rst_ni && sel_req && !fifo_full;
    assign data_we_o    = (winner == REQ_M1) ? m1_we_i    : m0_we_i;
    assign data_be_o    = (winner == REQ_M1) ? m1_be_i    : m0_be_i;
    assign data_addr_o  = (winner == REQ_M1) ? m1_addr_i  : m0_addr_i;
    assign data_wdata_o = (winner == REQ_M1) ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o = data_req_o && data_gnt_i && (winner == REQ_M0);
    assign m1_gnt_o = data_req_o && data_gnt_i && (winner == REQ_M1);

    assign push = data_req_o && data_gnt_i;
    assign pop  = rst_ni && data_rvalid_i && !fifo_empty;

    assign m0_rvalid_o        = pop && (head_id == REQ_M0);
    assign m1_rvalid_o        = pop && (head_id == REQ_M1);
    assign m0_rdata_o         = data_rdata_i;
    assign m1_rdata_o         = data_rdata_i;
    assign err_unexp_rvalid_o = rst_ni && data_rvalid_i && fifo_empty;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        if (push) begin
            rr_d = ~winner;
        end
        case (state_q)
            ARB: begin
                if (data_req_o && !data_gnt_i) begin
                    state_d = HOLD;
                    lock_d  = winner;
                end
            end
            HOLD: begin
                if (!sel_req || data_gnt_i) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            rr_q    <= REQ_M0;
            lock_q  <= REQ_M0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    cv32e40p_data_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .id_i    (winner),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_id),
        .count_o (out_cnt)
    );

endmodule
